// File: rtl/hdmi_timing_pkg.sv
// Shared HDMI timing types and 720p defaults, used by the transmit and receive paths.
package hdmi_timing_pkg;

    typedef logic [11:0] cnt_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tg_state_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } timing_t;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;

    // MSB replication keeps full-scale 565 values at full-scale 888.
    function automatic rgb888_t rgb565_to_888(input rgb565_t p);
        rgb888_t o;
        o.r = {p.r, p.r[4:2]};
        o.g = {p.g, p.g[5:4]};
        o.b = {p.b, p.b[4:2]};
        return o;
    endfunction

endpackage

// File: rtl/hdmi_data_out_if.sv
// Pixel request bus and encoder-facing video outputs of hdmi_data_out.
interface hdmi_data_out_if;
    import hdmi_timing_pkg::*;

    // pix_req is a fixed-latency request with no ready: pix_valid/pix_data answer
    // exactly RD_LATENCY cycles later, and the source must keep up every cycle.
    logic        pix_req;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        frame_start;
    logic        hs_out;
    logic        vs_out;
    logic        de_out;
    logic [23:0] rgb_out;
    logic        underflow;
    tg_state_t   dbg_state;

    modport master (
        output pix_req, frame_start, hs_out, vs_out, de_out, rgb_out, underflow, dbg_state,
        input  pix_data, pix_valid
    );

    modport slave (
        input  pix_req, frame_start, hs_out, vs_out, de_out, rgb_out, underflow, dbg_state,
        output pix_data, pix_valid
    );

endinterface

// File: rtl/hdmi_timing_gen.sv
// Line/frame counters, run/idle FSM and raw de/hs/vs/frame_start decode.
module hdmi_timing_gen
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P,
    parameter int H_FP     = H_FP_720P,
    parameter int H_SYNC   = H_SYNC_720P,
    parameter int H_BP     = H_BP_720P,
    parameter int V_ACTIVE = V_ACTIVE_720P,
    parameter int V_FP     = V_FP_720P,
    parameter int V_SYNC   = V_SYNC_720P,
    parameter int V_BP     = V_BP_720P
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      enable,
    output logic      de_o,
    output logic      hs_o,
    output logic      vs_o,
    output logic      frame_start_o,
    output tg_state_t state_o
);

    localparam cnt_t H_ACT    = cnt_t'(H_ACTIVE);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t H_LAST   = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam cnt_t V_ACT    = cnt_t'(V_ACTIVE);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam cnt_t V_LAST   = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    tg_state_t state_q, state_d;
    cnt_t      h_cnt_q, h_cnt_d;
    cnt_t      v_cnt_q, v_cnt_d;
    logic      run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // enable only matters in IDLE and on the final pixel of a frame, so frames are never cut short.
    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        case (state_q)
            ST_IDLE: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (h_cnt_q == H_LAST) begin
                    h_cnt_d = '0;
                    if (v_cnt_q == V_LAST) begin
                        v_cnt_d = '0;
                        if (!enable) state_d = ST_IDLE;
                    end else begin
                        v_cnt_d = v_cnt_q + 12'd1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 12'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        run           = (state_q == ST_RUN);
        de_o          = run && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_o          = run && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vs_o          = run && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        frame_start_o = run && (h_cnt_q == '0) && (v_cnt_q == '0);
        state_o       = state_q;
    end

endmodule

// File: rtl/hdmi_data_out.sv
// HDMI transmit timing generator and RGB565-to-888 pixel output stage with underflow flag.
module hdmi_data_out
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_720P,
    parameter int H_FP       = H_FP_720P,
    parameter int H_SYNC     = H_SYNC_720P,
    parameter int H_BP       = H_BP_720P,
    parameter int V_ACTIVE   = V_ACTIVE_720P,
    parameter int V_FP       = V_FP_720P,
    parameter int V_SYNC     = V_SYNC_720P,
    parameter int V_BP       = V_BP_720P,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int RD_LATENCY = 2
) (
    input  logic            hdmi_pix_clk,
    input  logic            rst,
    input  logic            enable,
    hdmi_data_out_if.master bus
);

    logic      raw_de, raw_hs, raw_vs, fs;
    tg_state_t state;
    timing_t   raw, dly;
    timing_t [RD_LATENCY-1:0] pipe_q, pipe_d;

    logic    de_out_q, de_out_d;
    logic    hs_out_q, hs_out_d;
    logic    vs_out_q, vs_out_d;
    rgb888_t rgb_out_q, rgb_out_d;
    logic    miss_q, miss_d;
    logic    underflow_q, underflow_d;

    hdmi_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing_gen (
        .clk          (hdmi_pix_clk),
        .rst          (rst),
        .enable       (enable),
        .de_o         (raw_de),
        .hs_o         (raw_hs),
        .vs_o         (raw_vs),
        .frame_start_o(fs),
        .state_o      (state)
    );

    // Timing is delayed by the reader latency so sync stays aligned with returned pixels.
    always_comb begin
        raw.de    = raw_de;
        raw.hs    = raw_hs;
        raw.vs    = raw_vs;
        pipe_d    = pipe_q;
        pipe_d[0] = raw;
        for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
        dly = pipe_q[RD_LATENCY-1];
    end

    always_comb begin
        de_out_d    = dly.de;
        hs_out_d    = dly.hs ? HS_POL : ~HS_POL;
        vs_out_d    = dly.vs ? VS_POL : ~VS_POL;
        miss_d      = dly.de && !bus.pix_valid;
        rgb_out_d   = (dly.de && bus.pix_valid) ? rgb565_to_888(bus.pix_data) : '0;
        underflow_d = (underflow_q && !fs) || miss_q;
    end

    always_ff @(posedge hdmi_pix_clk) begin
        if (rst) begin
            pipe_q      <= '0;
            de_out_q    <= 1'b0;
            hs_out_q    <= ~HS_POL;
            vs_out_q    <= ~VS_POL;
            rgb_out_q   <= '0;
            miss_q      <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pipe_q      <= pipe_d;
            de_out_q    <= de_out_d;
            hs_out_q    <= hs_out_d;
            vs_out_q    <= vs_out_d;
            rgb_out_q   <= rgb_out_d;
            miss_q      <= miss_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.pix_req     = raw_de;
    assign bus.frame_start = fs;
    assign bus.de_out      = de_out_q;
    assign bus.hs_out      = hs_out_q;
    assign bus.vs_out      = vs_out_q;
    assign bus.rgb_out     = rgb_out_q;
    assign bus.underflow   = underflow_q && !fs;
    assign bus.dbg_state   = state;

endmodule

// File: tb/tb_hdmi_data_out.sv
// Directed bench for hdmi_data_out on a 14x7 raster with a 2-cycle upstream reader model.
module tb_hdmi_data_out;
    import hdmi_timing_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    int vectors = 0;
    int miscompares = 0;
    int unsigned cyc = 0;
    logic [23:0] exp_q[$];

    hdmi_data_out_if bus();

    hdmi_data_out #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .RD_LATENCY(2)
    ) dut (
        .hdmi_pix_clk(clk),
        .rst         (rst),
        .enable      (enable),
        .bus         (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input string tag);
        int n;
        n = 0;
        step();
        while (!bus.frame_start && n < 200) begin
            step();
            n++;
        end
        vectors++;
        if (!bus.frame_start) begin
            miscompares++;
            $error("FAIL %s frame_start timeout observed=0 expected=1", tag);
        end
    endtask

    function automatic logic [23:0] exp_rgb(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
    endfunction

    // ---------------- upstream reader model (2-cycle latency) ----------------
    logic        drop_arm;
    logic        h_req0, h_req1, h_drop0, h_drop1;
    logic [15:0] h_dat0, h_dat1;
    logic [23:0] h_exp0, h_exp1;
    int          req_idx;

    always @(negedge clk) begin
        if (rst) begin
            h_req0 = 1'b0;
            h_req1 = 1'b0;
            bus.pix_valid = 1'b0;
            bus.pix_data  = 16'h0;
            req_idx = 0;
        end else begin
            if (h_req1) begin
                bus.pix_data  = h_dat1;
                bus.pix_valid = !h_drop1;
                exp_q.push_back(h_drop1 ? 24'h000000 : h_exp1);
            end else begin
                bus.pix_data  = 16'($urandom_range(0, 65535));
                bus.pix_valid = 1'($urandom_range(0, 1));
            end
            h_req1  = h_req0;
            h_dat1  = h_dat0;
            h_exp1  = h_exp0;
            h_drop1 = h_drop0;
            h_req0  = bus.pix_req;
            h_drop0 = 1'b0;
            if (bus.frame_start) req_idx = 0;
            if (bus.pix_req) begin
                case (req_idx)
                    0: begin h_dat0 = 16'hF800; h_exp0 = 24'hFF0000; end
                    1: begin h_dat0 = 16'h07E0; h_exp0 = 24'h00FF00; end
                    2: begin h_dat0 = 16'h0010; h_exp0 = 24'h000084; end
                    3: begin h_dat0 = 16'hFFFF; h_exp0 = 24'hFFFFFF; end
                    default: begin
                        h_dat0 = 16'($urandom_range(0, 65535));
                        h_exp0 = exp_rgb(h_dat0);
                    end
                endcase
                if (drop_arm && req_idx == 21) h_drop0 = 1'b1;
                req_idx++;
            end
        end
    end

    // ---------------- scoreboard and per-frame monitor ----------------
    logic frame_chk;
    logic have_prev = 1'b0;
    logic hs_prev = 1'b0, vs_prev = 1'b0;
    int   period = 0, req_n = 0, de_n = 0, hs_rise = 0, vs_rise = 0, hs_len = 0, vs_len = 0;

    always @(negedge clk) begin
        if (bus.de_out) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL sb_underrun observed=de_out expected=queued pixel");
            end else begin
                check("rgb", bus.rgb_out, exp_q.pop_front());
            end
        end else begin
            check("rgb_blank", bus.rgb_out, 24'h0);
        end

        if (bus.frame_start) begin
            if (have_prev) begin
                check("fs_period", period, 98);
                check("req_per_frame", req_n, 32);
                check("de_per_frame", de_n, 32);
                check("hs_pulses", hs_rise, 7);
                check("vs_pulses", vs_rise, 1);
            end
            have_prev = frame_chk;
            period = 0; req_n = 0; de_n = 0; hs_rise = 0; vs_rise = 0;
        end
        period++;
        if (bus.pix_req) req_n++;
        if (bus.de_out) de_n++;

        if (bus.hs_out && !hs_prev) hs_rise++;
        if (bus.hs_out) hs_len++;
        else begin
            if (hs_prev) check("hs_width", hs_len, 2);
            hs_len = 0;
        end
        if (bus.vs_out && !vs_prev) vs_rise++;
        if (bus.vs_out) vs_len++;
        else begin
            if (vs_prev) check("vs_width", vs_len, 14);
            vs_len = 0;
        end
        hs_prev = bus.hs_out;
        vs_prev = bus.vs_out;

        if (rst || !frame_chk) have_prev = 1'b0;
        if (rst) exp_q.delete();
    end

    // ---------------- directed sequence ----------------
    int unsigned t0;
    int n, a_req, a_de, a_fs, a_hs, a_vs;
    logic a_hs_prev, a_vs_prev;

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        frame_chk = 1'b1;
        drop_arm = 1'b0;
        repeat (3) step();

        check("rst_pix_req", bus.pix_req, 0);
        check("rst_frame_start", bus.frame_start, 0);
        check("rst_de_out", bus.de_out, 0);
        check("rst_rgb_out", bus.rgb_out, 0);
        check("rst_underflow", bus.underflow, 0);
        check("rst_hs_out", bus.hs_out, 0);
        check("rst_vs_out", bus.vs_out, 0);
        check("rst_state", bus.dbg_state, ST_IDLE);

        // start of run
        rst = 1'b0;
        enable = 1'b1;
        step();
        check("start_frame_start", bus.frame_start, 1);
        check("start_pix_req", bus.pix_req, 1);
        check("start_hs_out", bus.hs_out, 0);
        check("start_vs_out", bus.vs_out, 0);
        t0 = cyc;
        n = 0;
        while (!bus.de_out && n < 10) begin
            step();
            n++;
        end
        check("first_de_latency", cyc - t0, 3);
        check("first_de_hs_out", bus.hs_out, 0);

        // three free-running frames, checked by the monitor
        repeat (3) wait_fs("free_run");

        // underflow on pixel 5 of line 2
        drop_arm = 1'b1;
        repeat (36) step();
        check("drop_de_out", bus.de_out, 1);
        check("drop_rgb_out", bus.rgb_out, 0);
        check("drop_underflow_before", bus.underflow, 0);
        drop_arm = 1'b0;
        step();
        check("underflow_rise", bus.underflow, 1);
        repeat (60) step();
        check("underflow_hold", bus.underflow, 1);
        step();
        check("underflow_fs", bus.frame_start, 1);
        check("underflow_clear", bus.underflow, 0);
        step();
        check("underflow_stay_clear", bus.underflow, 0);

        // enable dropped at h=3,v=1: frame completes, then IDLE
        wait_fs("pre_disable");
        frame_chk = 1'b0;
        a_req = bus.pix_req ? 1 : 0;
        a_de = bus.de_out ? 1 : 0;
        a_fs = 0; a_hs = 0; a_vs = 0;
        a_hs_prev = bus.hs_out;
        a_vs_prev = bus.vs_out;
        for (int i = 1; i < 268; i++) begin
            step();
            if (i == 17) enable = 1'b0;
            if (bus.pix_req) a_req++;
            if (bus.de_out) a_de++;
            if (bus.frame_start) a_fs++;
            if (bus.hs_out && !a_hs_prev) a_hs++;
            if (bus.vs_out && !a_vs_prev) a_vs++;
            a_hs_prev = bus.hs_out;
            a_vs_prev = bus.vs_out;
        end
        check("disable_req_count", a_req, 32);
        check("disable_de_count", a_de, 32);
        check("disable_no_fs", a_fs, 0);
        check("disable_hs_pulses", a_hs, 7);
        check("disable_vs_pulses", a_vs, 1);
        check("disable_state", bus.dbg_state, ST_IDLE);

        // restart, then reset mid-active-line with an underflow pending
        enable = 1'b1;
        step();
        check("restart_frame_start", bus.frame_start, 1);
        check("restart_pix_req", bus.pix_req, 1);
        check("restart_state", bus.dbg_state, ST_RUN);
        drop_arm = 1'b1;
        repeat (37) step();
        check("pre_rst_underflow", bus.underflow, 1);
        drop_arm = 1'b0;
        repeat (9) step();
        check("pre_rst_de_out", bus.de_out, 1);
        rst = 1'b1;
        step();
        check("midrst_de_out", bus.de_out, 0);
        check("midrst_pix_req", bus.pix_req, 0);
        check("midrst_underflow", bus.underflow, 0);
        check("midrst_frame_start", bus.frame_start, 0);
        check("midrst_hs_out", bus.hs_out, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_frame_start", bus.frame_start, 1);
        check("post_rst_pix_req", bus.pix_req, 1);
        wait_fs("post_rst_frame");
        check("sb_drained", exp_q.size(), 0);
        check("post_rst_underflow", bus.underflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
